// File: rtl/register_file.sv
// 31-entry register file with x0 hard-wired to zero, two combinational read ports,
// a debug read port and a sequential whole-file clear that runs one register per cycle.
module register_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [4:0]       write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [4:0]       read_addr_1,
    input  logic [4:0]       read_addr_2,
    output logic [WIDTH-1:0] read_data_1,
    output logic [WIDTH-1:0] read_data_2,
    input  logic [4:0]       debug_addr,
    output logic [WIDTH-1:0] debug_data,
    input  logic             clear_req,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    logic [WIDTH-1:0] regs [1:31];
    state_t           state;
    logic [4:0]       clear_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs[i[4:0]] <= '0;
            end
            state     <= IDLE;
            clear_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A write in the clear_req cycle still lands; the clear overwrites it later.
                    if (write_enable && (write_addr != 5'd0)) begin
                        regs[write_addr] <= write_data;
                    end
                    if (clear_req) begin
                        state     <= CLEAR;
                        clear_idx <= 5'd1;
                    end
                end
                CLEAR: begin
                    regs[clear_idx] <= '0;
                    if (clear_idx == 5'd31) begin
                        state <= IDLE;
                    end else begin
                        clear_idx <= clear_idx + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == CLEAR);

    // x0 has no storage, so index 0 is decoded to zero on every read port.
    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        debug_data  = '0;
        if (read_addr_1 != 5'd0) read_data_1 = regs[read_addr_1];
        if (read_addr_2 != 5'd0) read_data_2 = regs[read_addr_2];
        if (debug_addr != 5'd0)  debug_data  = regs[debug_addr];
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected outputs from an array model,
// a negedge monitor pops and compares against the DUT.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_enable = 1'b0;
    logic [4:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_addr_1 = '0;
    logic [4:0]  read_addr_2 = '0;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [4:0]  debug_addr = '0;
    logic [31:0] debug_data;
    logic        clear_req = 1'b0;
    logic        busy;

    register_file #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .debug_addr(debug_addr), .debug_data(debug_data),
        .clear_req(clear_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] dbg;
        logic        bsy;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    // Reference model: plain array plus "next register to clear" (0 = not clearing).
    logic [31:0] mem [32];
    int          clr_pos = 0;

    task automatic step(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                        input bit cr);
        exp_t e;
        reset = rst; write_enable = we; write_addr = wa; write_data = wd;
        read_addr_1 = a1; read_addr_2 = a2; debug_addr = ad; clear_req = cr;
        e.rd1 = mem[a1]; e.rd2 = mem[a2]; e.dbg = mem[ad];
        e.bsy = (clr_pos != 0); e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            clr_pos = 0;
        end else if (clr_pos != 0) begin
            mem[clr_pos] = 32'h0;
            clr_pos = (clr_pos == 31) ? 0 : clr_pos + 1;
        end else begin
            if (we && wa != 5'd0) mem[wa] = wd;
            if (cr) clr_pos = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        step(1'b0, 1'b0, 5'd0, 32'h0, a1, a2, ad, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (read_data_1 !== e.rd1) begin
                failures++;
                $display("FAIL rd1 cyc=%0d addr=%0d got=%h exp=%h", e.cyc, read_addr_1, read_data_1, e.rd1);
            end
            checks++;
            if (read_data_2 !== e.rd2) begin
                failures++;
                $display("FAIL rd2 cyc=%0d addr=%0d got=%h exp=%h", e.cyc, read_addr_2, read_data_2, e.rd2);
            end
            checks++;
            if (debug_data !== e.dbg) begin
                failures++;
                $display("FAIL dbg cyc=%0d addr=%0d got=%h exp=%h", e.cyc, debug_addr, debug_data, e.dbg);
            end
            checks++;
            if (busy !== e.bsy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, busy, e.bsy);
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hX;
        mem[0] = 32'h0;
        @(posedge clk); #1;

        // Reset
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 5'd3, 32'h1111, 5'd3, 5'd0, 5'd0, 1'b1);
        idle_read(5'd3, 5'd31, 5'd1);

        // No bypass on x5, then visible on all ports
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 1'b0);
        idle_read(5'd5, 5'd5, 5'd5);

        // Writes to x0 are dropped
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) idle_read(5'd0, 5'd0, 5'd0);

        // Fill with index values, clear, probe boundary k / k+1 each cycle
        for (int r = 1; r < 32; r++) step(1'b0, 1'b1, r[4:0], r, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd7, 1'b1);
        for (int k = 1; k <= 31; k++) begin
            logic [4:0] a, b;
            a = k[4:0];
            b = (k == 31) ? 5'd31 : 5'(k + 1);
            if (k == 3)
                step(1'b0, 1'b1, 5'd7, 32'h12345678, a, b, 5'd7, 1'b0);
            else if (k == 10)
                step(1'b0, 1'b0, 5'd0, 32'h0, a, b, 5'd20, 1'b1);
            else
                step(1'b0, 1'b0, 5'd0, 32'h0, a, b, 5'($urandom_range(31)), 1'b0);
        end
        for (int r = 0; r < 32; r += 2) idle_read(r[4:0], 5'(r + 1), 5'd7);

        // Reset during clear aborts it
        step(1'b0, 1'b1, 5'd20, 32'hA5A5A5A5, 5'd20, 5'd0, 5'd20, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd0, 5'd20, 1'b1);
        for (int k = 1; k <= 14; k++) idle_read(5'd20, k[4:0], 5'd20);
        step(1'b1, 1'b1, 5'd9, 32'h99, 5'd20, 5'd15, 5'd20, 1'b1);
        idle_read(5'd20, 5'd9, 5'd20);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit rst, we, cr;
            rst = ($urandom_range(299) == 0);
            we  = ($urandom_range(3) != 0);
            cr  = ($urandom_range(79) == 0);
            step(rst, we, 5'($urandom_range(31)), $urandom,
                 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)), cr);
        end

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, bit width of each register and of all data ports.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: write_enable  input  1  request to write write_data into write_addr this cycle.
REQ-005 SHALL have port: write_addr  input  5  destination register index.
REQ-006 SHALL have port: write_data  input  WIDTH  value to write.
REQ-007 SHALL have port: read_addr_1  input  5  source register index, read port 1.
REQ-008 SHALL have port: read_addr_2  input  5  source register index, read port 2.
REQ-009 SHALL have port: read_data_1  output  WIDTH  contents of register read_addr_1.
REQ-010 SHALL have port: read_data_2  output  WIDTH  contents of register read_addr_2.
REQ-011 SHALL have port: debug_addr  input  5  register index for the debug/observation port.
REQ-012 SHALL have port: debug_data  output  WIDTH  contents of register debug_addr.
REQ-013 SHALL have port: clear_req  input  1  single-cycle request to start a sequential clear of all registers.
REQ-014 SHALL have port: busy  output  1  high while a sequential clear is in progress.
REQ-015 Clock/reset SHALL be: one clock (clk); reset is synchronous and active-high.

Function
REQ-016 SHALL hold 31 WIDTH-bit storage registers x1..x31; x0 has no storage.
REQ-017 Any read of index 0 on any read/debug port SHALL return all-zero.
REQ-018 Read ports SHALL be purely combinational 32-to-1 selections of current stored contents; zero read latency.
REQ-019 Reads SHALL NOT bypass: a read of write_addr in the write cycle returns the old value; the new value is visible from the cycle after the edge.
REQ-020 Write SHALL occur at the rising edge when write_enable=1, busy=0, reset=0 and write_addr!=0.
REQ-021 Writes with write_addr=0 SHALL be silently discarded.
REQ-022 Writes presented while busy=1 SHALL be discarded (no queuing, no error flag).
REQ-023 Clear FSM SHALL have two states: IDLE and CLEAR.
REQ-024 IDLE -> CLEAR SHALL occur at the edge where clear_req=1 in IDLE; a 5-bit clear index loads 1.
REQ-025 A write accepted in the same cycle as clear_req SHALL still be performed (it is later overwritten by the clear).
REQ-026 In CLEAR, each edge SHALL zero register x[clear index] and increment the index by 1.
REQ-027 CLEAR -> IDLE SHALL occur at the edge that zeroes x31; the index does not wrap past 31.
REQ-028 busy SHALL equal (state == CLEAR); a clear therefore holds busy high for exactly 31 cycles.
REQ-029 clear_req while in CLEAR SHALL be ignored (no restart, no extension).
REQ-030 Reads during CLEAR SHALL return the current, partially cleared contents.

Reset
REQ-031 On reset=1 at a rising edge: all x1..x31 SHALL become 0, state IDLE, clear index 0, busy 0.
REQ-032 Reset SHALL take priority over write and clear_req in the same cycle.
REQ-033 Reset during CLEAR SHALL abort the clear; busy is 0 from the next cycle.

Verification
REQ-034 Bench SHALL cover: reset, then write x5=0xDEADBEEF -> same cycle read_data_1(addr 5)=0; next cycle=0xDEADBEEF on read_data_1, read_data_2 and debug_data.
REQ-035 Bench SHALL cover: write x0=0xFFFFFFFF -> read_data_1(addr 0)=0 in all following cycles.
REQ-036 Bench SHALL cover: fill x1..x31 with index value, pulse clear_req -> busy high exactly 31 cycles; after cycle k of CLEAR, x1..xk=0 and x(k+1)..x31 unchanged; all zero once busy falls.
REQ-037 Bench SHALL cover: write x7=0x12345678 with busy=1 -> x7 remains 0 after clear completes.
REQ-038 Bench SHALL cover: clear_req again at CLEAR cycle 10 -> busy still falls after cycle 31 of the original clear.
REQ-039 Bench SHALL cover: reset at CLEAR cycle 15 with x20=0xA5A5A5A5 -> next cycle busy=0 and x20=0.
